// File: rtl/sopc_pio_in_edge_if.sv
// Avalon-MM slave bus bundle for the edge-capturing input PIO.
// The processor side drives the strobes; the PIO returns read data and its interrupt.
interface sopc_pio_in_edge_if;
   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;
   logic        irq;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata, irq
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata, irq
   );
endinterface

// File: rtl/sopc_pio_in_edge.sv
// Parametrised input PIO: synchronised inputs, sticky per-bit edge capture with
// W1C clear, maskable level/edge interrupt, standard four-word PIO register map.
module sopc_pio_in_edge #(
   parameter int WIDTH       = 8,
   parameter int SYNC_STAGES = 2,
   parameter int EDGE_TYPE   = 0,
   parameter int IRQ_MODE    = 2
) (
   input  logic               clk,
   input  logic               reset_n,
   sopc_pio_in_edge_if.slave  bus,
   input  logic [WIDTH-1:0]   in_port
);

   localparam int WARM = SYNC_STAGES + 1;

   logic [WIDTH-1:0] sync_q [SYNC_STAGES];
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] prev;
   logic [WIDTH-1:0] irq_mask;
   logic [WIDTH-1:0] edge_cap;
   logic [WIDTH-1:0] detected;
   logic [WIDTH-1:0] clear;
   logic [2:0]       warm_cnt;
   logic             warm_done;
   logic             wr_en;
   logic [31:0]      data_ext;
   logic [31:0]      mask_ext;
   logic [31:0]      cap_ext;
   logic [31:0]      rd_next;
   logic             irq_next;
   logic             unused_wdata;

   assign unused_wdata = ^bus.writedata;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= in_port;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end

   assign sync      = sync_q[SYNC_STAGES-1];
   assign warm_done = (warm_cnt == 3'(WARM));
   assign wr_en     = bus.chipselect & ~bus.write_n;

   // Warm-up masks the first sync/prev mismatch seen after reset for inputs already high.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev     <= '0;
         warm_cnt <= '0;
      end else begin
         prev <= sync;
         if (!warm_done) warm_cnt <= warm_cnt + 3'd1;
      end
   end

   always_comb begin
      detected = '0;
      if (warm_done) begin
         case (EDGE_TYPE)
            0:       detected = sync & ~prev;
            1:       detected = ~sync & prev;
            default: detected = sync ^ prev;
         endcase
      end
   end

   always_comb begin
      clear = '0;
      if (wr_en && bus.address == 2'd3) clear = bus.writedata[WIDTH-1:0];
   end

   // A new edge wins over a simultaneous W1C on the same bit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_mask <= '0;
         edge_cap <= '0;
      end else begin
         if (wr_en && bus.address == 2'd2) irq_mask <= bus.writedata[WIDTH-1:0];
         edge_cap <= (edge_cap & ~clear) | detected;
      end
   end

   always_comb begin
      data_ext = '0;
      mask_ext = '0;
      cap_ext  = '0;
      data_ext[WIDTH-1:0] = sync;
      mask_ext[WIDTH-1:0] = irq_mask;
      cap_ext[WIDTH-1:0]  = edge_cap;
      case (bus.address)
         2'd0:    rd_next = data_ext;
         2'd2:    rd_next = mask_ext;
         2'd3:    rd_next = cap_ext;
         default: rd_next = '0;
      endcase
   end

   always_comb begin
      case (IRQ_MODE)
         1:       irq_next = |(sync & irq_mask);
         2:       irq_next = |(edge_cap & irq_mask);
         default: irq_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bus.readdata <= '0;
         bus.irq      <= 1'b0;
      end else begin
         bus.readdata <= rd_next;
         bus.irq      <= irq_next;
      end
   end

endmodule
